// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state type and default PC width.
package core_pkg;

  // Default PC/address width shared by the fetch and branch stages.
  localparam int unsigned PC_W = 12;

  // Fetch-stage run lifecycle.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/pc_watchdog.sv
// Run-cycle counter with watchdog compare for the fetch stage.
module pc_watchdog #(
  parameter int unsigned           CW      = 16,
  parameter logic [CW-1:0]         TIMEOUT = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          count_en,
  output logic [CW-1:0] cycle_count,
  output logic          expire
);

  // Limit reached; stays asserted while the count is parked at TIMEOUT.
  assign expire = (cycle_count == TIMEOUT);

  // Count RUN cycles; hold at TIMEOUT so the counter can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (clear) begin
      cycle_count <= '0;
    end else if (count_en && !expire) begin
      cycle_count <= cycle_count + CW'(1);
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter stage: architectural PC, ROM address, run lifecycle
// (start / stall / halt) and watchdog-forced halt.
module pc_fetch
  import core_pkg::*;
#(
  parameter int unsigned   D          = PC_W,
  parameter logic [D-1:0]  START_ADDR = '0,
  parameter int unsigned   CW         = 16,
  parameter logic [CW-1:0] TIMEOUT    = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic          halt,
  input  logic [D-1:0]  pc_next,
  output logic [D-1:0]  pc,
  output logic [D-1:0]  pc_inc,
  output logic          running,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  fetch_state_t state;
  logic         wd_clear;
  logic         wd_count_en;
  logic         wd_expire;

  // A start is honoured only outside RUN; it also restarts the watchdog.
  assign wd_clear    = start && (state != RUN);
  assign wd_count_en = (state == RUN);

  pc_watchdog #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (wd_clear),
    .count_en    (wd_count_en),
    .cycle_count (cycle_count),
    .expire      (wd_expire)
  );

  // Status decodes straight from state, no extra register stage.
  assign running = (state == RUN);
  assign done    = (state == HALTED);

  // Sequential PC feeding the branch stage; wraps modulo 2^D.
  assign pc_inc = pc + D'(1);

  // Lifecycle FSM and PC register: watchdog > stall > halt > advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      timeout <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state   <= RUN;
            pc      <= START_ADDR;
            timeout <= 1'b0;
          end
        end
        RUN: begin
          if (wd_expire) begin
            state   <= HALTED;
            timeout <= 1'b1;
          end else if (stall) begin
            state <= RUN;
          end else if (halt) begin
            state <= HALTED;
          end else begin
            pc <= pc_next;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed table, hand sequences,
// and randomized stimulus against a behavioural model.
module tb_pc_fetch;

  localparam int unsigned D  = 12;
  localparam int unsigned CW = 16;
  localparam int unsigned M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, stall, halt;
  logic [D-1:0]  pc_next;
  logic [D-1:0]  a_pc, a_inc, b_pc, b_inc;
  logic          a_run, a_done, a_to, b_run, b_done, b_to;
  logic [CW-1:0] a_cnt, b_cnt;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  pc_fetch #(.D(D), .START_ADDR(12'h000), .CW(CW), .TIMEOUT(16'hFFFF)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .pc_next(pc_next), .pc(a_pc), .pc_inc(a_inc), .running(a_run),
    .done(a_done), .timeout(a_to), .cycle_count(a_cnt));

  pc_fetch #(.D(D), .START_ADDR(12'h000), .CW(CW), .TIMEOUT(16'd8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .pc_next(pc_next), .pc(b_pc), .pc_inc(b_inc), .running(b_run),
    .done(b_done), .timeout(b_to), .cycle_count(b_cnt));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned st;
    logic [11:0] pc;
    int unsigned cnt;
    bit          to;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = M_IDLE; r.pc = '0; r.cnt = 0; r.to = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int unsigned tmo,
                                 input bit s, input bit sl, input bit hl,
                                 input logic [11:0] nx);
    mdl_t r;
    r = m;
    if (m.st == M_RUN) begin
      if (m.cnt == tmo) begin
        r.st = M_HALT;
        r.to = 1'b1;
      end else begin
        r.cnt = m.cnt + 1;
        if (!sl) begin
          if (hl) r.st = M_HALT;
          else    r.pc = nx;
        end
      end
    end else if (s) begin
      r.st = M_RUN; r.pc = '0; r.cnt = 0; r.to = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, 32'hFFFF, start, stall, halt, pc_next);
    mb = mstep(mb, 8, start, stall, halt, pc_next);
    #1;
  endtask

  task automatic cmp_model(input int unsigned cyc);
    logic [11:0] ea, eb;
    ea = ma.pc + 12'd1;
    eb = mb.pc + 12'd1;
    chk($sformatf("rnd%0d a_pc", cyc),   32'(a_pc),   32'(ma.pc));
    chk($sformatf("rnd%0d a_inc", cyc),  32'(a_inc),  32'(ea));
    chk($sformatf("rnd%0d a_run", cyc),  32'(a_run),  32'(ma.st == M_RUN));
    chk($sformatf("rnd%0d a_done", cyc), 32'(a_done), 32'(ma.st == M_HALT));
    chk($sformatf("rnd%0d a_to", cyc),   32'(a_to),   32'(ma.to));
    chk($sformatf("rnd%0d a_cnt", cyc),  32'(a_cnt),  ma.cnt);
    chk($sformatf("rnd%0d b_pc", cyc),   32'(b_pc),   32'(mb.pc));
    chk($sformatf("rnd%0d b_inc", cyc),  32'(b_inc),  32'(eb));
    chk($sformatf("rnd%0d b_run", cyc),  32'(b_run),  32'(mb.st == M_RUN));
    chk($sformatf("rnd%0d b_done", cyc), 32'(b_done), 32'(mb.st == M_HALT));
    chk($sformatf("rnd%0d b_to", cyc),   32'(b_to),   32'(mb.to));
    chk($sformatf("rnd%0d b_cnt", cyc),  32'(b_cnt),  mb.cnt);
  endtask

  typedef struct {
    bit          s, sl, hl;
    logic [11:0] nx;
    logic [11:0] pc;
    bit          run, done, to;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit sl, input bit hl, input logic [11:0] nx,
                              input logic [11:0] pc, input bit run, input bit done,
                              input logic [15:0] cnt);
    vec_t v;
    v.s = s; v.sl = sl; v.hl = hl; v.nx = nx;
    v.pc = pc; v.run = run; v.done = done; v.to = 1'b0; v.cnt = cnt;
    return v;
  endfunction

  vec_t tbl[17];

  initial begin
    //            s  sl hl nx       pc       run done cnt
    tbl[0]  = mk(1, 0, 0, 12'h000, 12'h000, 1, 0, 16'd0);
    tbl[1]  = mk(0, 0, 0, 12'h001, 12'h001, 1, 0, 16'd1);
    tbl[2]  = mk(0, 0, 0, 12'h002, 12'h002, 1, 0, 16'd2);
    tbl[3]  = mk(0, 0, 0, 12'h003, 12'h003, 1, 0, 16'd3);
    tbl[4]  = mk(0, 0, 0, 12'h004, 12'h004, 1, 0, 16'd4);
    tbl[5]  = mk(0, 0, 0, 12'h040, 12'h040, 1, 0, 16'd5);
    tbl[6]  = mk(0, 1, 0, 12'h123, 12'h040, 1, 0, 16'd6);
    tbl[7]  = mk(0, 1, 0, 12'h124, 12'h040, 1, 0, 16'd7);
    tbl[8]  = mk(0, 1, 0, 12'h125, 12'h040, 1, 0, 16'd8);
    tbl[9]  = mk(0, 0, 0, 12'h041, 12'h041, 1, 0, 16'd9);
    tbl[10] = mk(0, 1, 1, 12'h055, 12'h041, 1, 0, 16'd10);
    tbl[11] = mk(0, 1, 1, 12'h056, 12'h041, 1, 0, 16'd11);
    tbl[12] = mk(0, 0, 1, 12'h077, 12'h041, 0, 1, 16'd12);
    tbl[13] = mk(0, 1, 0, 12'h078, 12'h041, 0, 1, 16'd12);
    tbl[14] = mk(1, 0, 1, 12'h079, 12'h000, 1, 0, 16'd0);
    tbl[15] = mk(1, 0, 0, 12'h005, 12'h005, 1, 0, 16'd1);
    tbl[16] = mk(0, 0, 1, 12'h006, 12'h005, 0, 1, 16'd2);

    rst_n = 1'b0; start = 1'b0; stall = 1'b0; halt = 1'b0; pc_next = '0;
    ma = mreset(); mb = mreset();

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst pc",   32'(a_pc),   32'h0);
    chk("rst run",  32'(a_run),  32'h0);
    chk("rst done", 32'(a_done), 32'h0);
    chk("rst cnt",  32'(a_cnt),  32'h0);
    chk("rst to",   32'(a_to),   32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle%0d pc", i),   32'(a_pc),   32'h0);
      chk($sformatf("idle%0d run", i),  32'(a_run),  32'h0);
      chk($sformatf("idle%0d done", i), 32'(a_done), 32'h0);
      chk($sformatf("idle%0d cnt", i),  32'(a_cnt),  32'h0);
    end

    // Sequential run, jump, stall, halt under stall, restart
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].s; stall = tbl[i].sl; halt = tbl[i].hl; pc_next = tbl[i].nx;
      tick();
      chk($sformatf("row%0d pc", i),   32'(a_pc),   32'(tbl[i].pc));
      chk($sformatf("row%0d run", i),  32'(a_run),  32'(tbl[i].run));
      chk($sformatf("row%0d done", i), 32'(a_done), 32'(tbl[i].done));
      chk($sformatf("row%0d to", i),   32'(a_to),   32'(tbl[i].to));
      chk($sformatf("row%0d cnt", i),  32'(a_cnt),  32'(tbl[i].cnt));
    end
    start = 1'b0; stall = 1'b0; halt = 1'b0;

    // Watchdog (TIMEOUT=8) and pc_inc wrap on u_b
    start = 1'b1; tick(); start = 1'b0;
    chk("wd start pc",  32'(b_pc),  32'h0);
    chk("wd start cnt", 32'(b_cnt), 32'h0);
    chk("wd start run", 32'(b_run), 32'h1);
    pc_next = 12'hFFE; tick();
    chk("wd pc ffe", 32'(b_pc), 32'hFFE);
    pc_next = b_inc; tick();
    chk("wd pc fff",  32'(b_pc),  32'hFFF);
    chk("wd inc wrap", 32'(b_inc), 32'h000);
    for (int k = 0; k < 6; k++) begin
      pc_next = b_inc; tick();
    end
    chk("wd pre pc",  32'(b_pc),  32'h005);
    chk("wd pre cnt", 32'(b_cnt), 32'd8);
    chk("wd pre to",  32'(b_to),  32'h0);
    chk("wd pre run", 32'(b_run), 32'h1);
    pc_next = b_inc; tick();
    chk("wd fire to",   32'(b_to),   32'h1);
    chk("wd fire done", 32'(b_done), 32'h1);
    chk("wd fire run",  32'(b_run),  32'h0);
    chk("wd fire pc",   32'(b_pc),   32'h005);
    chk("wd fire cnt",  32'(b_cnt),  32'd8);
    pc_next = 12'h3AA; tick();
    chk("wd hold pc", 32'(b_pc), 32'h005);
    chk("wd hold to", 32'(b_to), 32'h1);
    start = 1'b1; tick(); start = 1'b0;
    chk("wd restart to",  32'(b_to),  32'h0);
    chk("wd restart pc",  32'(b_pc),  32'h0);
    chk("wd restart run", 32'(b_run), 32'h1);

    // Asynchronous reset mid-run
    pc_next = 12'h123; tick();
    chk("arst pre pc", 32'(a_pc), 32'h123);
    #2 rst_n = 1'b0;
    #1;
    chk("arst pc",   32'(a_pc),  32'h0);
    chk("arst run",  32'(a_run), 32'h0);
    chk("arst cnt",  32'(a_cnt), 32'h0);
    chk("arst b pc", 32'(b_pc),  32'h0);
    ma = mreset(); mb = mreset();
    @(negedge clk);
    rst_n = 1'b1;
    pc_next = '0;

    // Randomized stimulus against the behavioural model
    for (int c = 0; c < 800; c++) begin
      start   = ($urandom_range(0, 15) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      halt    = ($urandom_range(0, 7) == 0);
      pc_next = $urandom_range(0, 1) ? 12'($urandom) : 12'(ma.pc + 12'd1);
      tick();
      cmp_model(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
